// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: OpenMIPS IF stage, ROM fetch into a prefetch FIFO with valid/ready to ID.
// Optional perf counters are built when IF_PERF_EN is defined.
module inst_fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  input  logic        id_ready_i,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_bubble_o,
  output logic [31:0] perf_redir_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc_q;
  logic          ce_q;
  logic [31:0]   mem_pc   [FIFO_DEPTH];
  logic [31:0]   mem_inst [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, pop, keep, capture;
  logic [31:0]   pc_next;
  assign full       = count == CW'(FIFO_DEPTH);
  assign if_valid_o = count != '0;
  assign pop        = if_valid_o & id_ready_i;
  // a taken branch with a non-empty FIFO means the head is the delay slot
  assign keep       = branch_flag_i & ~flush_i & if_valid_o;
  assign capture    = ce_q & (~full | pop) & ~flush_i & ~keep;
  assign rom_ce_o   = ce_q;
  assign rom_addr_o = pc_q;
  assign if_pc_o    = if_valid_o ? mem_pc[rd_ptr] : 32'h0;
  assign if_inst_o  = if_valid_o ? mem_inst[rd_ptr] : 32'h0;
  always_comb
    pc_next = flush_i ? (new_pc_i & ~32'h3) :
              branch_flag_i ? (branch_target_i & ~32'h3) :
              capture ? pc_q + 32'd4 : pc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q   <= RESET_PC & ~32'h3;
      ce_q   <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      ce_q <= 1'b1;
      pc_q <= pc_next;
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (keep) begin
        rd_ptr <= rd_ptr + AW'(pop);
        wr_ptr <= rd_ptr + AW'(1);
        count  <= pop ? CW'(0) : CW'(1);
      end else begin
        rd_ptr <= rd_ptr + AW'(pop);
        wr_ptr <= wr_ptr + AW'(capture);
        count  <= count + CW'(capture) - CW'(pop);
      end
    end
  always_ff @(posedge clk)
    if (capture) begin
      mem_pc[wr_ptr]   <= pc_q;
      mem_inst[wr_ptr] <= rom_inst_i;
    end
`ifdef IF_PERF_EN
  logic [31:0] fetch_q, bubble_q, redir_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_q  <= '0;
      bubble_q <= '0;
      redir_q  <= '0;
    end else begin
      fetch_q  <= fetch_q + 32'(capture);
      bubble_q <= bubble_q + 32'(~if_valid_o);
      redir_q  <= redir_q + 32'(flush_i | branch_flag_i);
    end
  assign perf_fetch_o  = fetch_q;
  assign perf_bubble_o = bubble_q;
  assign perf_redir_o  = redir_q;
`else
  assign perf_fetch_o  = 32'h0;
  assign perf_bubble_o = 32'h0;
  assign perf_redir_o  = 32'h0;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of fetch stream, stall, branch delay slot, flush and PC wrap.
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, flush, branch, ready;
  logic [31:0] new_pc, target;
  logic        ce, valid;
  logic [31:0] addr, rom_inst, if_pc, if_inst, pf, pb, pr;
  logic        w_ce, w_valid;
  logic [31:0] w_addr, w_inst, w_pc, w_if_inst, w_pf, w_pb, w_pr;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  assign rom_inst = addr >> 2;
  assign w_inst   = w_addr >> 2;
  inst_fetch_unit u_dut (
    .clk(clk), .rst(rst), .flush_i(flush), .new_pc_i(new_pc),
    .branch_flag_i(branch), .branch_target_i(target),
    .rom_ce_o(ce), .rom_addr_o(addr), .rom_inst_i(rom_inst),
    .if_valid_o(valid), .if_pc_o(if_pc), .if_inst_o(if_inst), .id_ready_i(ready),
    .perf_fetch_o(pf), .perf_bubble_o(pb), .perf_redir_o(pr)
  );
  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .flush_i(1'b0), .new_pc_i(32'h0),
    .branch_flag_i(1'b0), .branch_target_i(32'h0),
    .rom_ce_o(w_ce), .rom_addr_o(w_addr), .rom_inst_i(w_inst),
    .if_valid_o(w_valid), .if_pc_o(w_pc), .if_inst_o(w_if_inst), .id_ready_i(1'b1),
    .perf_fetch_o(w_pf), .perf_bubble_o(w_pb), .perf_redir_o(w_pr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; branch = 1'b0; ready = 1'b1;
    new_pc = 32'h0; target = 32'h0;
    tick;
    chk("rst_ce", 32'(ce), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_waddr", w_addr, 32'hFFFF_FFF8);
    chk("rst_perf", pf | pb | pr, 32'h0);
    rst = 1'b0;
    tick;
    chk("ce_up", 32'(ce), 32'h1);
    chk("addr0", addr, 32'h0);
    chk("valid_lat1", 32'(valid), 32'h0);
    tick;
    chk("valid_lat2", 32'(valid), 32'h1);
    chk("stream_pc0", if_pc, 32'h0);
    chk("stream_inst0", if_inst, 32'h0);
    chk("stream_addr", addr, 32'h4);
    for (int k = 1; k < 4; k++) begin
      tick;
      chk("stream_pc", if_pc, 32'(4 * k));
      chk("stream_inst", if_inst, 32'(k));
    end
    chk("stream_addr3", addr, 32'h10);
    // asynchronous reset in the middle of a cycle, then stall ID
    #2; rst = 1'b1; ready = 1'b0;
    #1;
    chk("arst_ce", 32'(ce), 32'h0);
    chk("arst_addr", addr, 32'h0);
    chk("arst_valid", 32'(valid), 32'h0);
    tick; rst = 1'b0;
    tick;
    chk("wrap_a0", w_addr, 32'hFFFF_FFF8);
    tick;
    chk("wrap_a1", w_addr, 32'hFFFF_FFFC);
    chk("wrap_h0", w_pc, 32'hFFFF_FFF8);
    tick;
    chk("wrap_a2", w_addr, 32'h0);
    chk("wrap_h1", w_pc, 32'hFFFF_FFFC);
    chk("wrap_i1", w_if_inst, 32'h3FFF_FFFF);
    tick;
    chk("wrap_a3", w_addr, 32'h4);
    chk("wrap_h2", w_pc, 32'h0);
`ifdef IF_PERF_EN
    chk("wperf_fetch", w_pf, 32'd3);
    chk("wperf_bubble", w_pb, 32'd2);
    chk("wperf_redir", w_pr, 32'd0);
`else
    chk("wperf_off", w_pf | w_pb | w_pr, 32'h0);
`endif
    repeat (6) tick;
    chk("full_addr", addr, 32'h10);
    chk("full_valid", 32'(valid), 32'h1);
    chk("full_head", if_pc, 32'h0);
    ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      tick;
      chk("drain_pc", if_pc, 32'(4 * k));
      chk("drain_inst", if_inst, 32'(k));
    end
    // branch with delay slot at head, ID stalled
    rst = 1'b1; tick; rst = 1'b0;
    repeat (5) tick;
    chk("br_head", if_pc, 32'hC);
    branch = 1'b1; target = 32'h40; ready = 1'b0;
    tick;
    branch = 1'b0; ready = 1'b1;
    chk("br_keep_pc", if_pc, 32'hC);
    chk("br_keep_addr", addr, 32'h40);
    tick;
    chk("br_tgt", if_pc, 32'h40);
    chk("br_tgt_inst", if_inst, 32'h10);
    tick;
    chk("br_tgt4", if_pc, 32'h44);
    // branch while delay slot pops, then branch with FIFO empty
    branch = 1'b1; target = 32'h83;
    tick;
    chk("brp_valid", 32'(valid), 32'h0);
    chk("brp_addr", addr, 32'h80);
    target = 32'h100;
    tick;
    branch = 1'b0;
    chk("bre_slot", if_pc, 32'h80);
    chk("bre_inst", if_inst, 32'h20);
    chk("bre_addr", addr, 32'h100);
    tick;
    chk("bre_tgt", if_pc, 32'h100);
    chk("bre_addr2", addr, 32'h104);
    // flush beats branch
    ready = 1'b0;
    tick; tick;
    chk("fl_pre", addr, 32'h10C);
    flush = 1'b1; branch = 1'b1; new_pc = 32'h180; target = 32'h40; ready = 1'b1;
    tick;
    flush = 1'b0; branch = 1'b0;
    chk("fl_valid", 32'(valid), 32'h0);
    chk("fl_pc", if_pc, 32'h0);
    chk("fl_addr", addr, 32'h180);
    tick;
    chk("fl_head", if_pc, 32'h180);
    chk("fl_inst", if_inst, 32'h60);
    chk("fl_addr2", addr, 32'h184);
`ifdef IF_PERF_EN
    chk("perf_fetch", pf, 32'd11);
    chk("perf_bubble", pb, 32'd4);
    chk("perf_redir", pr, 32'd4);
`else
    chk("perf_off", pf | pb | pr, 32'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
